// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: word geometry, butterfly sequencer states
// and the per-component complex negate used on the subtract pass.
package fft_pkg;

  localparam int DATA_W    = 16;
  localparam int HALF_W    = DATA_W / 2;
  localparam int FRAC_BITS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    DIFF = 2'd2,
    OUT  = 2'd3
  } state_e;

  // Each half negates on its own and wraps, so -(0x80) stays 0x80.
  function automatic logic [DATA_W-1:0] cneg(input logic [DATA_W-1:0] word);
    logic [HALF_W-1:0] re_n;
    logic [HALF_W-1:0] im_n;
    re_n = -word[DATA_W-1:HALF_W];
    im_n = -word[HALF_W-1:0];
    return {re_n, im_n};
  endfunction

endpackage

// File: rtl/complex_add.sv
// Combinational complex adder: independent wrap-around add of the packed
// real (upper half) and imaginary (lower half) components.
module complex_add #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_A,
  input  logic [DATA_W-1:0] i_B,
  output logic [DATA_W-1:0] o_sum
);

  localparam int HALF_W = DATA_W / 2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_comp
      assign o_sum[gi*HALF_W +: HALF_W] = i_A[gi*HALF_W +: HALF_W] + i_B[gi*HALF_W +: HALF_W];
    end
  endgenerate

endmodule

// File: rtl/butterfly_add_seq.sv
// Radix-2 butterfly sequencer: one shared complex adder produces A+B then
// A-B for each accepted pair, presenting both on a valid/ready output.
module butterfly_add_seq
  import fft_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int BLOCK_LEN = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_A,
  input  logic [DATA_W-1:0] i_B,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_top,
  output logic [DATA_W-1:0] o_bot,
  output logic              o_last,
  output logic              o_busy
);

  localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLOCK_LEN - 1);

  state_e            state_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] top_reg;
  logic [DATA_W-1:0] bot_reg;
  logic              valid_reg;
  logic              last_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic [DATA_W-1:0] add_b;
  logic [DATA_W-1:0] add_sum;
  logic              cnt_at_max;

  // The adder sees B on the SUM pass and -B on the DIFF pass.
  assign add_b = (state_reg == DIFF) ? cneg(b_reg) : b_reg;

  complex_add #(
    .DATA_W(DATA_W)
  ) u_add (
    .i_A  (a_reg),
    .i_B  (add_b),
    .o_sum(add_sum)
  );

  assign cnt_at_max = (cnt_reg == CNT_MAX);

  // Ready depends only on state and downstream ready, never on i_valid.
  assign o_ready = (state_reg == IDLE) | ((state_reg == OUT) & i_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      top_reg   <= '0;
      bot_reg   <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_valid) begin
            a_reg     <= i_A;
            b_reg     <= i_B;
            state_reg <= SUM;
          end
        end
        SUM: begin
          top_reg   <= add_sum;
          state_reg <= DIFF;
        end
        DIFF: begin
          bot_reg   <= add_sum;
          last_reg  <= cnt_at_max;
          valid_reg <= 1'b1;
          state_reg <= OUT;
        end
        OUT: begin
          if (i_ready) begin
            valid_reg <= 1'b0;
            cnt_reg   <= cnt_at_max ? '0 : cnt_reg + 1'b1;
            if (i_valid) begin
              a_reg     <= i_A;
              b_reg     <= i_B;
              state_reg <= SUM;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_valid = valid_reg;
  assign o_top   = top_reg;
  assign o_bot   = bot_reg;
  assign o_last  = last_reg;
  assign o_busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_butterfly_add_seq.sv
// Self-checking bench for butterfly_add_seq: fixed vectors, randomized pairs
// against an arithmetic reference, streaming, backpressure and reset abort.
module tb_butterfly_add_seq;

  localparam int DW = 16;
  localparam int BL = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_A = '0;
  logic [DW-1:0] i_B = '0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [DW-1:0] o_top;
  logic [DW-1:0] o_bot;
  logic          o_last;
  logic          o_busy;

  int errors = 0;
  int checks = 0;
  int model_idx = 0;
  int accepts = 0;
  int consumed = 0;

  butterfly_add_seq #(
    .DATA_W   (DW),
    .BLOCK_LEN(BL)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_A    (i_A),
    .i_B    (i_B),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_top  (o_top),
    .o_bot  (o_bot),
    .o_last (o_last),
    .o_busy (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] top;
    logic [15:0] bot;
    int          hold;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: signed per-component arithmetic, wrapped to 8 bits.
  function automatic logic [15:0] ref_bfly(input logic [15:0] a, input logic [15:0] b, input bit sub);
    int ar, ai, br, bi, r, i;
    ar = int'($signed(a[15:8]));
    ai = int'($signed(a[7:0]));
    br = int'($signed(b[15:8]));
    bi = int'($signed(b[7:0]));
    r  = sub ? ar - br : ar + br;
    i  = sub ? ai - bi : ai + bi;
    return {r[7:0], i[7:0]};
  endfunction

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_rst_n = 1'b0;
    tick;
    tick;
    i_rst_n = 1'b1;
    model_idx = 0;
    tick;
  endtask

  // One pair through IDLE -> SUM -> DIFF -> OUT, optional i_ready hold in OUT.
  task automatic run_pair(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_top, input logic [15:0] exp_bot,
                          input int hold);
    int   lat;
    logic exp_last;
    chk("ready_in_idle", {31'd0, o_ready}, 32'd1);
    i_A = a;
    i_B = b;
    i_valid = 1'b1;
    i_ready = 1'b1;
    tick;
    i_valid = 1'b0;
    i_A = 16'($urandom);
    i_B = 16'($urandom);
    lat = 1;
    while (!o_valid && lat < 10) begin
      tick;
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    exp_last = ((model_idx % BL) == BL - 1);
    chk("top", {16'd0, o_top}, {16'd0, exp_top});
    chk("bot", {16'd0, o_bot}, {16'd0, exp_bot});
    chk("last", {31'd0, o_last}, {31'd0, exp_last});
    $display("pair %0d A=%h B=%h top=%h bot=%h last=%b hold=%0d", model_idx, a, b, o_top, o_bot, o_last, hold);
    if (hold > 0) begin
      i_ready = 1'b0;
      i_valid = 1'b1;
      i_A = 16'($urandom);
      i_B = 16'($urandom);
      repeat (hold) begin
        tick;
        chk("hold_valid", {31'd0, o_valid}, 32'd1);
        chk("hold_top", {16'd0, o_top}, {16'd0, exp_top});
        chk("hold_bot", {16'd0, o_bot}, {16'd0, exp_bot});
        chk("hold_ready", {31'd0, o_ready}, 32'd0);
      end
      i_valid = 1'b0;
    end
    i_ready = 1'b1;
    tick;
    model_idx++;
    chk("consumed_valid", {31'd0, o_valid}, 32'd0);
    chk("consumed_busy", {31'd0, o_busy}, 32'd0);
  endtask

  // Nine pairs with i_valid and i_ready held high.
  task automatic stream_test;
    logic [15:0] pa[9];
    logic [15:0] pb[9];
    int   k_in, k_out, cyc, last_cyc;
    bit   hs;
    logic exp_last;
    for (int i = 0; i < 9; i++) begin
      pa[i] = 16'($urandom);
      pb[i] = 16'($urandom);
    end
    k_in = 0;
    k_out = 0;
    cyc = 0;
    last_cyc = 0;
    i_ready = 1'b1;
    i_A = pa[0];
    i_B = pb[0];
    i_valid = 1'b1;
    hs = o_ready;
    while (k_out < 9 && cyc < 100) begin
      tick;
      cyc++;
      if (hs) begin
        k_in++;
        if (k_in < 9) begin
          i_A = pa[k_in];
          i_B = pb[k_in];
        end else begin
          i_valid = 1'b0;
        end
      end
      if (o_valid) begin
        exp_last = ((model_idx % BL) == BL - 1);
        chk("stream_top", {16'd0, o_top}, {16'd0, ref_bfly(pa[k_out], pb[k_out], 1'b0)});
        chk("stream_bot", {16'd0, o_bot}, {16'd0, ref_bfly(pa[k_out], pb[k_out], 1'b1)});
        chk("stream_last", {31'd0, o_last}, {31'd0, exp_last});
        if (k_out > 0) chk("stream_gap", 32'(cyc - last_cyc), 32'd3);
        $display("stream %0d A=%h B=%h top=%h bot=%h last=%b cyc=%0d", k_out + 1, pa[k_out], pb[k_out], o_top, o_bot, o_last, cyc);
        last_cyc = cyc;
        k_out++;
        model_idx++;
      end
      hs = i_valid & o_ready;
    end
    chk("stream_count", 32'(k_out), 32'd9);
    tick;
    chk("stream_idle", {31'd0, o_busy}, 32'd0);
  endtask

  // Track handshakes to catch a result that no accepted pair produced.
  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      accepts  <= 0;
      consumed <= 0;
    end else begin
      if (i_valid && o_ready) accepts <= accepts + 1;
      if (o_valid && i_ready) consumed <= consumed + 1;
    end
  end

  always @(negedge i_clk) begin
    if (o_valid) chk("valid_without_accept", {31'd0, (accepts > consumed)}, 32'd1);
    if (o_busy && !o_valid) chk("ready_in_sum_diff", {31'd0, o_ready}, 32'd0);
  end

  initial begin
    logic [15:0] ra, rb;
    vecs[0] = '{16'h0AEF, 16'h0D16, 16'h1705, 16'hFDD9, 0};
    vecs[1] = '{16'h7F7F, 16'h0101, 16'h8080, 16'h7E7E, 0};
    vecs[2] = '{16'h0000, 16'h8080, 16'h8080, 16'h8080, 5};
    vecs[3] = '{16'h8000, 16'h0080, 16'h8080, 16'h8080, 0};
    vecs[4] = '{16'h1234, 16'h1111, 16'h2345, 16'h0123, 1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 16'hFEFE, 16'h0000, 0};

    tick;
    tick;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_top", {16'd0, o_top}, 32'd0);
    chk("rst_bot", {16'd0, o_bot}, 32'd0);
    chk("rst_last", {31'd0, o_last}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    i_rst_n = 1'b1;
    model_idx = 0;
    tick;

    for (int i = 0; i < 6; i++)
      run_pair(vecs[i].a, vecs[i].b, vecs[i].top, vecs[i].bot, vecs[i].hold);

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_pair(ra, rb, ref_bfly(ra, rb, 1'b0), ref_bfly(ra, rb, 1'b1), int'($urandom_range(0, 2)));
    end

    do_reset;
    stream_test;

    // Reset during DIFF aborts the pair and clears the block position.
    do_reset;
    run_pair(vecs[4].a, vecs[4].b, vecs[4].top, vecs[4].bot, 0);
    run_pair(vecs[1].a, vecs[1].b, vecs[1].top, vecs[1].bot, 0);
    i_A = vecs[0].a;
    i_B = vecs[0].b;
    i_valid = 1'b1;
    tick;
    i_valid = 1'b0;
    tick;
    chk("mid_top_before_rst", {16'd0, o_top}, {16'd0, vecs[0].top});
    chk("mid_busy_before_rst", {31'd0, o_busy}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_top", {16'd0, o_top}, 32'd0);
    chk("mid_rst_bot", {16'd0, o_bot}, 32'd0);
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    $display("reset asserted mid-pair top=%h bot=%h valid=%b", o_top, o_bot, o_valid);
    tick;
    i_rst_n = 1'b1;
    model_idx = 0;
    tick;
    run_pair(vecs[0].a, vecs[0].b, vecs[0].top, vecs[0].bot, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
